// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command controller.
// ERR_CODE and TIMEOUT_CYC are only referenced when ALU_CTRL_TIMEOUT_EN is defined.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    GET_FUN  = 3'd3,
    ALU_RUN  = 3'd4,
    WAIT_RES = 3'd5,
    SEND_LO  = 3'd6,
    SEND_HI  = 3'd7
  } ctrl_state_t;

  localparam logic [7:0]  CMD_OPER    = 8'hCC;
  localparam logic [7:0]  CMD_FUNC    = 8'hDD;
  localparam int          TIMEOUT_CYC = 8;
  localparam logic [15:0] ERR_CODE    = 16'h00EE;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// RX / ALU / TX signal bundle; the controller sits on the slave modport.
interface alu_cmd_ctrl_if #(
  parameter int Op_Width  = 8,
  parameter int Fun_Width = 4
);
  logic [7:0]            RX_P_DATA;
  logic                  RX_D_VLD;
  logic [Op_Width-1:0]   ALU_A;
  logic [Op_Width-1:0]   ALU_B;
  logic [Fun_Width-1:0]  ALU_FUN;
  logic                  ALU_EN;
  logic [2*Op_Width-1:0] ALU_OUT;
  logic                  OUT_VALID;
  logic [7:0]            TX_P_DATA;
  logic                  TX_D_VLD;
  logic                  TX_BUSY;
  logic                  CTRL_BUSY;

  modport slave (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY
  );

  modport master (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CTRL_BUSY
  );
endinterface

// File: rtl/alu_ctrl_txser.sv
// Two-byte result serializer: low byte first, then high byte, each held until the
// transmitter accepts it (valid high and busy low).
module alu_ctrl_txser #(
  parameter int Res_Width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [Res_Width-1:0] result,
  input  logic                 tx_busy,
  output logic                 tx_vld,
  output logic [7:0]           tx_data,
  output logic                 accept
);

  logic hi;

  assign accept = tx_vld & ~tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_vld <= 1'b0;
      hi     <= 1'b0;
    end else if (load) begin
      tx_vld <= 1'b1;
      hi     <= 1'b0;
    end else if (accept) begin
      if (hi) tx_vld <= 1'b0;
      hi <= ~hi;
    end
  end

  // Data is a pure function of registers, so it cannot move while the transmitter stalls.
  assign tx_data = !tx_vld ? 8'h00 : (hi ? result[15:8] : result[7:0]);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command controller: parses 0xCC/0xDD frames from RX, runs the ALU and returns the result over TX.
// Define ALU_CTRL_TIMEOUT_EN to bound the wait for OUT_VALID and return ERR_CODE on expiry.
import alu_ctrl_pkg::*;

module alu_cmd_ctrl #(
  parameter int Op_Width  = 8,
  parameter int Fun_Width = 4
) (
  input logic           CLK,
  input logic           RST,
  alu_cmd_ctrl_if.slave bus
);

  ctrl_state_t           state, state_nxt;
  logic [Op_Width-1:0]   a_reg, b_reg;
  logic [Fun_Width-1:0]  fun_reg;
  logic [2*Op_Width-1:0] result, res_nxt;
  logic                  res_load;
  logic                  alu_en;
  logic                  tx_accept;

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt;
  logic            to_expired;

  // Held at zero outside WAIT_RES, so every entry starts a fresh count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                   to_cnt <= '0;
    else if (state != WAIT_RES) to_cnt <= '0;
    else                        to_cnt <= to_cnt + 1'b1;
  end

  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

  always_comb begin
    state_nxt = state;
    res_load  = 1'b0;
    res_nxt   = bus.ALU_OUT;
    case (state)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_OPER)      state_nxt = GET_A;
          else if (bus.RX_P_DATA == CMD_FUNC) state_nxt = GET_FUN;
        end
      end
      GET_A:   if (bus.RX_D_VLD) state_nxt = GET_B;
      GET_B:   if (bus.RX_D_VLD) state_nxt = GET_FUN;
      GET_FUN: if (bus.RX_D_VLD) state_nxt = ALU_RUN;
      ALU_RUN: state_nxt = WAIT_RES;
      WAIT_RES: begin
        if (bus.OUT_VALID) begin
          res_load  = 1'b1;
          state_nxt = SEND_LO;
        end
`ifdef ALU_CTRL_TIMEOUT_EN
        else if (to_expired) begin
          res_load  = 1'b1;
          res_nxt   = (2*Op_Width)'(ERR_CODE);
          state_nxt = SEND_LO;
        end
`endif
      end
      SEND_LO: if (tx_accept) state_nxt = SEND_HI;
      SEND_HI: if (tx_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU_EN is registered from the next state so it is high exactly for the ALU_RUN cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      fun_reg <= '0;
      result  <= '0;
      alu_en  <= 1'b0;
    end else begin
      state  <= state_nxt;
      alu_en <= (state_nxt == ALU_RUN);
      if (bus.RX_D_VLD) begin
        case (state)
          GET_A:   a_reg   <= Op_Width'(bus.RX_P_DATA);
          GET_B:   b_reg   <= Op_Width'(bus.RX_P_DATA);
          GET_FUN: fun_reg <= bus.RX_P_DATA[Fun_Width-1:0];
          default: ;
        endcase
      end
      if (res_load) result <= res_nxt;
    end
  end

  assign bus.ALU_A     = a_reg;
  assign bus.ALU_B     = b_reg;
  assign bus.ALU_FUN   = fun_reg;
  assign bus.ALU_EN    = alu_en;
  assign bus.CTRL_BUSY = (state != IDLE);

  alu_ctrl_txser #(
    .Res_Width (2*Op_Width)
  ) u_txser (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (res_load),
    .result  (result),
    .tx_busy (bus.TX_BUSY),
    .tx_vld  (bus.TX_D_VLD),
    .tx_data (bus.TX_P_DATA),
    .accept  (tx_accept)
  );

endmodule
